// File: rtl/ex_operand_stage.sv
// ID/EX stage register with operand forwarding and ALU operand select.
// Also supplies the forwarded rs2 value as store data for MEM.
module ex_operand_stage #(
    parameter int XLEN   = 32,
    parameter bit FWD_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [1:0]      id_alu_src_a,
    input  logic            id_alu_src_b,
    input  logic [3:0]      id_alu_control,
    input  logic            id_reg_write,
    input  logic            stall,
    input  logic            flush,
    input  logic            exm_reg_write,
    input  logic [4:0]      exm_rd,
    input  logic [XLEN-1:0] exm_result,
    input  logic            mwb_reg_write,
    input  logic [4:0]      mwb_rd,
    input  logic [XLEN-1:0] mwb_result,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_control,
    output logic            ex_valid,
    output logic            ex_reg_write,
    output logic [4:0]      ex_rd,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_store_data
);

    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [1:0]      src_a;
        logic            src_b;
        logic [3:0]      alu_control;
    } id_ex_t;

    id_ex_t d_id;
    id_ex_t q;

    always_comb begin
        d_id             = '0;
        d_id.valid       = id_valid;
        d_id.reg_write   = id_reg_write & id_valid;
        d_id.rd          = id_rd;
        d_id.rs1         = id_rs1;
        d_id.rs2         = id_rs2;
        d_id.pc          = id_pc;
        d_id.rs1_data    = id_rs1_data;
        d_id.rs2_data    = id_rs2_data;
        d_id.imm         = id_imm;
        d_id.src_a       = id_alu_src_a;
        d_id.src_b       = id_alu_src_b;
        d_id.alu_control = id_alu_control;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (flush) begin
            q <= '0;
        end else if (!stall) begin
            q <= d_id;
        end
    end

    logic            exm_ok;
    logic            mwb_ok;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    assign exm_ok = FWD_EN && exm_reg_write && (exm_rd != 5'd0);
    assign mwb_ok = FWD_EN && mwb_reg_write && (mwb_rd != 5'd0);

    // EX/MEM holds the younger result, so it beats MEM/WB.
    always_comb begin
        fwd_rs1 = q.rs1_data;
        if (exm_ok && exm_rd == q.rs1) begin
            fwd_rs1 = exm_result;
        end else if (mwb_ok && mwb_rd == q.rs1) begin
            fwd_rs1 = mwb_result;
        end
    end

    always_comb begin
        fwd_rs2 = q.rs2_data;
        if (exm_ok && exm_rd == q.rs2) begin
            fwd_rs2 = exm_result;
        end else if (mwb_ok && mwb_rd == q.rs2) begin
            fwd_rs2 = mwb_result;
        end
    end

    always_comb begin
        alu_a = '0;
        unique case (q.src_a)
            2'b00:   alu_a = fwd_rs1;
            2'b01:   alu_a = q.pc;
            default: alu_a = '0;
        endcase
    end

    assign alu_b         = q.src_b ? q.imm : fwd_rs2;
    assign ex_store_data = fwd_rs2;
    assign alu_control   = q.alu_control;
    assign ex_valid      = q.valid;
    assign ex_reg_write  = q.reg_write;
    assign ex_rd         = q.rd;
    assign ex_pc         = q.pc;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: reset, capture, forwarding,
// operand select, stall/flush and bubble behaviour.
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic [1:0]  id_alu_src_a;
    logic        id_alu_src_b;
    logic [3:0]  id_alu_control;
    logic        id_reg_write;
    logic        stall, flush;
    logic        exm_reg_write;
    logic [4:0]  exm_rd;
    logic [31:0] exm_result;
    logic        mwb_reg_write;
    logic [4:0]  mwb_rd;
    logic [31:0] mwb_result;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_control;
    logic        ex_valid, ex_reg_write;
    logic [4:0]  ex_rd;
    logic [31:0] ex_pc, ex_store_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_operand_stage #(.XLEN(32), .FWD_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_alu_src_a(id_alu_src_a),
        .id_alu_src_b(id_alu_src_b), .id_alu_control(id_alu_control),
        .id_reg_write(id_reg_write), .stall(stall), .flush(flush),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd),
        .exm_result(exm_result), .mwb_reg_write(mwb_reg_write),
        .mwb_rd(mwb_rd), .mwb_result(mwb_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_rd(ex_rd), .ex_pc(ex_pc), .ex_store_data(ex_store_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic v, input logic [31:0] pc,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] imm,
                        input logic [1:0] sa, input logic sb,
                        input logic [3:0] ctl, input logic rw);
        id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
        id_alu_src_a = sa; id_alu_src_b = sb;
        id_alu_control = ctl; id_reg_write = rw;
    endtask

    task automatic no_fwd();
        exm_reg_write = 0; exm_rd = 0; exm_result = 0;
        mwb_reg_write = 0; mwb_rd = 0; mwb_result = 0;
    endtask

    initial begin
        no_fwd();
        reset = 1; stall = 1; flush = 1;
        load(1, 32'h44, 5'd1, 5'd2, 5'd9, 32'h11, 32'h22, 32'h33,
             2'b01, 1'b1, 4'hf, 1);
        step();
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_ctl", {28'd0, alu_control}, 0);
        chk("rst_valid", {31'd0, ex_valid}, 0);
        chk("rst_rw", {31'd0, ex_reg_write}, 0);
        chk("rst_rd", {27'd0, ex_rd}, 0);
        chk("rst_pc", ex_pc, 0);
        chk("rst_store", ex_store_data, 0);

        // ADD x3,x1,x2
        reset = 0; stall = 0; flush = 0;
        load(1, 32'h100, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0,
             2'b00, 1'b0, 4'b0010, 1);
        step();
        chk("add_a", alu_a, 5);
        chk("add_b", alu_b, 7);
        chk("add_ctl", {28'd0, alu_control}, 32'h2);
        chk("add_rd", {27'd0, ex_rd}, 3);
        chk("add_rw", {31'd0, ex_reg_write}, 1);
        chk("add_valid", {31'd0, ex_valid}, 1);
        chk("add_pc", ex_pc, 32'h100);
        chk("add_store", ex_store_data, 7);

        // Forwarding on the held instruction
        stall = 1;
        exm_reg_write = 1; exm_rd = 1; exm_result = 100;
        mwb_reg_write = 1; mwb_rd = 1; mwb_result = 200;
        #1;
        chk("fwd_exm_wins", alu_a, 100);
        chk("fwd_b_none", alu_b, 7);
        mwb_rd = 2; mwb_result = 9;
        #1;
        chk("fwd_mwb_b", alu_b, 9);
        chk("fwd_mwb_store", ex_store_data, 9);
        chk("fwd_exm_a_keep", alu_a, 100);
        exm_reg_write = 0;
        mwb_reg_write = 0;
        #1;
        chk("fwd_exm_rw0", alu_a, 5);
        chk("fwd_mwb_rw0", alu_b, 7);

        // rs=0 is never forwarded
        stall = 0;
        exm_reg_write = 1; exm_rd = 0; exm_result = 55;
        mwb_reg_write = 1; mwb_rd = 0; mwb_result = 66;
        load(1, 32'h104, 5'd0, 5'd0, 5'd4, 32'd0, 32'd0, 32'd0,
             2'b00, 1'b0, 4'b0010, 1);
        step();
        chk("x0_a", alu_a, 0);
        chk("x0_b", alu_b, 0);
        no_fwd();

        // AUIPC
        load(1, 32'h1000, 5'd0, 5'd0, 5'd5, 32'd0, 32'd0, 32'h2000,
             2'b01, 1'b1, 4'b0010, 1);
        step();
        chk("auipc_a", alu_a, 32'h1000);
        chk("auipc_b", alu_b, 32'h2000);
        // LUI
        load(1, 32'h1004, 5'd0, 5'd0, 5'd6, 32'd0, 32'd0, 32'h5000,
             2'b10, 1'b1, 4'b0010, 1);
        step();
        chk("lui_a", alu_a, 0);
        chk("lui_b", alu_b, 32'h5000);
        load(1, 32'h1008, 5'd5, 5'd0, 5'd6, 32'hdead, 32'd0, 32'h1,
             2'b11, 1'b1, 4'b0010, 1);
        step();
        chk("srca11_a", alu_a, 0);

        // Store: sw x2, 8(x1)
        load(1, 32'h200, 5'd1, 5'd2, 5'd0, 32'h10, 32'h20, 32'd8,
             2'b00, 1'b1, 4'b0000, 0);
        step();
        chk("st_a", alu_a, 32'h10);
        chk("st_b", alu_b, 8);
        chk("st_data", ex_store_data, 32'h20);
        chk("st_rw", {31'd0, ex_reg_write}, 0);
        exm_reg_write = 1; exm_rd = 2; exm_result = 32'h77;
        #1;
        chk("st_fwd_data", ex_store_data, 32'h77);
        chk("st_fwd_b_imm", alu_b, 8);

        // Stall three cycles while ID changes
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            load(1, 32'h300 + i, 5'd7, 5'd8, 5'd9, 32'h1234, 32'h5678,
                 32'h99, 2'b01, 1'b0, 4'b0111, 1);
            step();
        end
        chk("stall_a", alu_a, 32'h10);
        chk("stall_b", alu_b, 8);
        chk("stall_pc", ex_pc, 32'h200);
        chk("stall_store", ex_store_data, 32'h77);
        chk("stall_ctl", {28'd0, alu_control}, 0);

        // Flush beats stall
        flush = 1;
        step();
        chk("flush_valid", {31'd0, ex_valid}, 0);
        chk("flush_rw", {31'd0, ex_reg_write}, 0);
        chk("flush_a", alu_a, 0);
        chk("flush_pc", ex_pc, 0);
        chk("flush_store", ex_store_data, 0);
        no_fwd();

        // id_valid=0 forces reg_write low
        flush = 0; stall = 0;
        load(0, 32'h400, 5'd1, 5'd2, 5'd10, 32'd1, 32'd2, 32'd0,
             2'b00, 1'b0, 4'b0010, 1);
        step();
        chk("inv_valid", {31'd0, ex_valid}, 0);
        chk("inv_rw", {31'd0, ex_reg_write}, 0);

        // Mid-operation reset
        load(1, 32'h500, 5'd1, 5'd2, 5'd11, 32'd3, 32'd4, 32'd0,
             2'b00, 1'b0, 4'b0010, 1);
        step();
        chk("pre_rst_a", alu_a, 3);
        reset = 1;
        step();
        chk("midrst_valid", {31'd0, ex_valid}, 0);
        chk("midrst_a", alu_a, 0);
        chk("midrst_rd", {27'd0, ex_rd}, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
